// File: rtl/unidade_mostra_sequencia_pkg.sv
// Shared definitions for the sequence presentation unit.
// Holds the FSM state encodings (which double as the db_estado debug codes)
// and the default presentation timing. The game control unit's timeout is
// meant to use the same constants, so all game timing has one source.
package unidade_mostra_sequencia_pkg;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  localparam int T_ACESO_PADRAO   = 500;
  localparam int T_APAGADO_PADRAO = 250;
  localparam int W_TIMER_PADRAO   = 10;

  localparam logic [3:0] DB_INVALIDO = 4'hF;

  // Debug code seen by the board: the encoding itself for legal states,
  // F for anything the register should never hold.
  function automatic logic [3:0] codigo_db(input estado_t estado);
    case (estado)
      OCIOSO, CARREGA, ACESO, APAGADO, PROXIMO, FIM: return estado;
      default:                                       return DB_INVALIDO;
    endcase
  endfunction

endpackage

// File: rtl/unidade_mostra_sequencia_contador_timer.sv
// contador_timer: W-bit up-counter used to time the lit and dark phases.
// Ports:
//   clock, reset  - system clock, async active-low reset
//   limpa         - synchronous clear (wins over conta)
//   conta         - count enable
//   limite        - terminal value to compare against
//   fim_contagem  - high while the count equals limite
module contador_timer
  #(parameter int W = 10)
  (input  logic         clock,
   input  logic         reset,
   input  logic         limpa,
   input  logic         conta,
   input  logic [W-1:0] limite,
   output logic         fim_contagem);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (limpa) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= contagem + W'(1);
    end
  end

  assign fim_contagem = (contagem == limite);

endmodule

// File: rtl/unidade_mostra_sequencia.sv
// unidade_mostra_sequencia: shows the stored colour sequence, entries
// 0..rodada, each lit for T_ACESO cycles then dark for T_APAGADO cycles,
// and pulses fim_mostra once when done.
// Ports:
//   clock, reset    - system clock, async active-low reset
//   iniciar_mostra  - start request (only looked at while idle)
//   rodada          - last entry index to show, latched at start
//   dado_memoria    - sequence memory read data for endereco
//   endereco        - sequence memory read address
//   leds            - one-hot colour, 0 while dark
//   mostrando       - busy flag
//   fim_mostra      - one-cycle completion pulse
//   db_estado       - debug state code
//
// state   | meaning
// --------+---------------------------------------------
// OCIOSO  | idle, waiting for iniciar_mostra
// CARREGA | capture memory word for current address
// ACESO   | pattern lit for T_ACESO cycles
// APAGADO | dark gap for T_APAGADO cycles
// PROXIMO | advance to next address
// FIM     | completion pulse, back to idle
module unidade_mostra_sequencia
  import unidade_mostra_sequencia_pkg::*;
  #(parameter int T_ACESO   = T_ACESO_PADRAO,
    parameter int T_APAGADO = T_APAGADO_PADRAO,
    parameter int W_TIMER   = W_TIMER_PADRAO)
  (input  logic       clock,
   input  logic       reset,
   input  logic       iniciar_mostra,
   input  logic [3:0] rodada,
   input  logic [3:0] dado_memoria,
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       mostrando,
   output logic       fim_mostra,
   output logic [3:0] db_estado);

  localparam logic [W_TIMER-1:0] LIM_ACESO   = W_TIMER'(T_ACESO - 1);
  localparam logic [W_TIMER-1:0] LIM_APAGADO = W_TIMER'(T_APAGADO - 1);

  estado_t estado, estado_prox;

  logic [3:0]         endereco_reg;
  logic [3:0]         rodada_reg;
  logic [3:0]         leds_reg;
  logic               timer_limpa;
  logic               timer_conta;
  logic [W_TIMER-1:0] timer_limite;
  logic               timer_fim;

  contador_timer #(.W(W_TIMER)) u_timer (
    .clock        (clock),
    .reset        (reset),
    .limpa        (timer_limpa),
    .conta        (timer_conta),
    .limite       (timer_limite),
    .fim_contagem (timer_fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (iniciar_mostra) estado_prox = CARREGA;
      CARREGA: estado_prox = ACESO;
      ACESO:   if (timer_fim) estado_prox = APAGADO;
      APAGADO: if (timer_fim)
                 estado_prox = (endereco_reg == rodada_reg) ? FIM : PROXIMO;
      PROXIMO: estado_prox = CARREGA;
      FIM:     estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_comb begin
    leds         = 4'd0;
    mostrando    = 1'b0;
    fim_mostra   = 1'b0;
    timer_limpa  = 1'b0;
    timer_conta  = 1'b0;
    timer_limite = LIM_APAGADO;
    case (estado)
      CARREGA: begin
        mostrando   = 1'b1;
        timer_limpa = 1'b1;
      end
      ACESO: begin
        mostrando    = 1'b1;
        leds         = leds_reg;
        timer_conta  = 1'b1;
        timer_limite = LIM_ACESO;
        timer_limpa  = timer_fim;
      end
      APAGADO: begin
        mostrando   = 1'b1;
        timer_conta = 1'b1;
        timer_limpa = timer_fim;
      end
      PROXIMO: mostrando = 1'b1;
      FIM: begin
        mostrando  = 1'b1;
        fim_mostra = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = codigo_db(estado);
  assign endereco  = endereco_reg;

  // Address is returned to 0 on the way out so the idle outputs are all zero.
  // endereco never passes rodada_reg, so the increment cannot wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco_reg <= 4'd0;
      rodada_reg   <= 4'd0;
      leds_reg     <= 4'd0;
    end else begin
      case (estado)
        OCIOSO: if (iniciar_mostra) begin
          rodada_reg   <= rodada;
          endereco_reg <= 4'd0;
        end
        CARREGA: leds_reg     <= dado_memoria;
        PROXIMO: endereco_reg <= endereco_reg + 4'd1;
        FIM:     endereco_reg <= 4'd0;
        default: ;
      endcase
    end
  end

endmodule
